// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter: derived widths and parameter
// legality helpers used by the top level and the response FIFO.
package shift_arbiter_pkg;

  // Width of a requester index; never narrower than one bit.
  function automatic int tag_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // Width able to hold 0..depth inclusive (pipeline plus FIFO occupancy).
  function automatic int inflight_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a FIFO read/write pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // The buffer must absorb a full shifter pipeline plus two entries of slack.
  function automatic bit fifo_depth_ok(input int depth, input int stages);
    return depth >= stages + 2;
  endfunction

  // The stages together must be able to shift by WIDTH-1 bits.
  function automatic bit shifter_reach_ok(input int width, input int stages,
                                          input int stage_pow);
    return stages * (1 << stage_pow) >= width - 1;
  endfunction

endpackage

// File: rtl/leftShiftPipelined.sv
// Pipelined left shifter: each stage shifts by at most 2^STAGE_POW bits and
// passes the remaining amount on; latency is exactly STAGES clocks.
module leftShiftPipelined #(
  parameter int WIDTH     = 140,
  parameter int STAGES    = 10,
  parameter int STAGE_POW = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_shift,
  output logic [WIDTH-1:0]           out_data
);

  localparam int SW   = $clog2(WIDTH);
  localparam int STEP = 1 << STAGE_POW;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] data_q;
    logic [SW-1:0]    r_in;
    logic [SW-1:0]    amt;

    if (s == 0) begin : g_first
      assign d_in = in_data;
      assign r_in = in_shift;
    end else begin : g_next
      assign d_in = g_stage[s-1].data_q;
      assign r_in = g_stage[s-1].g_carry.rem_q;
    end

    assign amt = (32'(r_in) > STEP) ? SW'(STEP) : r_in;

    // Shift this stage's share of the amount into the stage register.
    always_ff @(posedge clk) begin
      if (reset) data_q <= '0;
      else       data_q <= d_in << amt;
    end

    // The final stage consumes whatever remains, so it carries no remainder.
    if (s < STAGES - 1) begin : g_carry
      logic [SW-1:0] rem_q;
      // Carry the not-yet-applied shift amount to the next stage.
      always_ff @(posedge clk) begin
        if (reset) rem_q <= '0;
        else       rem_q <= r_in - amt;
      end
    end
  end

  assign out_data = g_stage[STAGES-1].data_q;

endmodule

// File: rtl/shift_rsp_fifo.sv
// Synchronous response FIFO holding {tag, data}; registered read pointer,
// output valid whenever non-empty (no fall-through), occupancy count output.
module shift_rsp_fifo
  import shift_arbiter_pkg::*;
#(
  parameter int DW    = 142,
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic [CW-1:0] count
);

  localparam int PW = ptr_width(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rd_valid = (count != '0);
  assign pop      = rd_en && rd_valid;
  assign push     = wr_en && ((count != CW'(DEPTH)) || pop);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  // Pointers and occupancy; a push and pop on the same edge leave count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage array; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter feeding a pipelined left shifter, with a tag/valid chain
// tracking each operation and a credit-checked response FIFO.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high. req_ready is a one-hot grant that depends combinationally on
// req_valid; rsp_data/rsp_tag stay stable while rsp_valid is high and
// rsp_ready is low.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int WIDTH      = 140,
  parameter int STAGES     = 10,
  parameter int STAGE_POW  = 4,
  parameter int NREQ       = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NREQ-1:0]                    req_valid,
  output logic [NREQ-1:0]                    req_ready,
  input  logic [NREQ*WIDTH-1:0]              req_data,
  input  logic [NREQ*$clog2(WIDTH)-1:0]      req_shift,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [WIDTH-1:0]                   rsp_data,
  output logic [tag_width(NREQ)-1:0]         rsp_tag,
  output logic [inflight_width(FIFO_DEPTH)-1:0] inflight
);

  localparam int SW = $clog2(WIDTH);
  localparam int TW = tag_width(NREQ);
  localparam int IW = inflight_width(FIFO_DEPTH);

  if (!fifo_depth_ok(FIFO_DEPTH, STAGES)) begin : g_bad_depth
    $error("shift_arbiter: FIFO_DEPTH must be at least STAGES+2");
  end
  if (!shifter_reach_ok(WIDTH, STAGES, STAGE_POW)) begin : g_bad_reach
    $error("shift_arbiter: STAGES*2^STAGE_POW cannot reach WIDTH-1");
  end

  logic [TW-1:0]    last_grant;
  logic [TW-1:0]    grant_idx;
  logic             grant_any;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic [SW-1:0]    sel_shift;
  logic [WIDTH-1:0] sh_data;
  logic [SW-1:0]    sh_shift;
  logic [WIDTH-1:0] sh_out;
  logic [STAGES-1:0] vld_q;
  logic [TW-1:0]    tag_q [STAGES];
  logic [IW-1:0]    pipe_cnt;
  logic [IW-1:0]    fifo_cnt;
  logic [TW+WIDTH-1:0] fifo_rd;

  // Round-robin search starting one past the last accepted requester.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_grant) + i) % NREQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = TW'(idx);
      end
    end
  end

  // Credit check against the current occupancy; a same-cycle pop is not counted.
  assign accept = grant_any && (inflight < IW'(FIFO_DEPTH)) && !reset;

  // One-hot grant to the selected requester when the credit check passes.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  assign sel_data  = req_data[int'(grant_idx)*WIDTH +: WIDTH];
  assign sel_shift = req_shift[int'(grant_idx)*SW +: SW];
  // Out-of-range shifts produce zero by feeding a zero operand.
  assign sh_data   = (!accept || (32'(sel_shift) >= WIDTH)) ? '0 : sel_data;
  assign sh_shift  = accept ? sel_shift : '0;

  // Round-robin pointer moves only on an acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_grant <= TW'(NREQ - 1);
    else if (accept) last_grant <= grant_idx;
  end

  leftShiftPipelined #(
    .WIDTH     (WIDTH),
    .STAGES    (STAGES),
    .STAGE_POW (STAGE_POW)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .in_data  (sh_data),
    .in_shift (sh_shift),
    .out_data (sh_out)
  );

  // Valid/tag chain aligned with the shifter's data pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int s = 0; s < STAGES; s++) tag_q[s] <= '0;
    end else begin
      vld_q[0] <= accept;
      tag_q[0] <= grant_idx;
      for (int s = 1; s < STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  // Number of operations currently inside the shifter.
  always_comb begin
    pipe_cnt = '0;
    for (int s = 0; s < STAGES; s++) pipe_cnt = pipe_cnt + IW'(vld_q[s]);
  end

  assign inflight = pipe_cnt + fifo_cnt;

  shift_rsp_fifo #(
    .DW    (TW + WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CW    (IW)
  ) u_rsp_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (vld_q[STAGES-1]),
    .wr_data  ({tag_q[STAGES-1], sh_out}),
    .rd_en    (rsp_ready),
    .rd_valid (rsp_valid),
    .rd_data  (fifo_rd),
    .count    (fifo_cnt)
  );

  assign rsp_data = fifo_rd[WIDTH-1:0];
  assign rsp_tag  = fifo_rd[WIDTH +: TW];

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed table of grant patterns, hand-written
// multi-cycle sequences, and an in-order scoreboard of data<<shift results.
module tb_shift_arbiter;

  localparam int WIDTH      = 140;
  localparam int STAGES     = 10;
  localparam int NREQ       = 4;
  localparam int FIFO_DEPTH = 16;
  localparam int SW         = 8;
  localparam int TW         = 2;
  localparam int IW         = 5;

  logic                    clk;
  logic                    reset;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*WIDTH-1:0]   req_data;
  logic [NREQ*SW-1:0]      req_shift;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [WIDTH-1:0]        rsp_data;
  logic [TW-1:0]           rsp_tag;
  logic [IW-1:0]           inflight;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;
  logic [TW+WIDTH-1:0] exp_q[$];

  typedef struct {
    logic [NREQ-1:0]  valid;
    logic [WIDTH-1:0] data;
    logic [SW-1:0]    shift;
    logic [NREQ-1:0]  exp_ready;
  } vec_t;
  vec_t vecs[12];

  shift_arbiter #(
    .WIDTH(WIDTH), .STAGES(STAGES), .STAGE_POW(4), .NREQ(NREQ), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_shift(req_shift), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .inflight(inflight)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_w(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_n(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [WIDTH-1:0] d, input logic [SW-1:0] s);
    req_data[r*WIDTH +: WIDTH] = d;
    req_shift[r*SW +: SW]      = s;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || inflight != '0) && n < 300) begin
      step();
      n++;
    end
    check_n("drain_empty", 32'(exp_q.size()) + 32'(inflight), 32'd0);
  endtask

  // Scoreboard: record accepted operations, compare responses in order
  always @(negedge clk) begin
    logic [WIDTH-1:0]    d;
    logic [SW-1:0]       sh;
    logic [TW+WIDTH-1:0] e;
    if (!reset) begin
      checks++;
      if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) begin
        errors++;
        $display("FAIL grant_onehot: req_ready %b req_valid %b", req_ready, req_valid);
      end
      for (int r = 0; r < NREQ; r++) begin
        if (req_valid[r] && req_ready[r]) begin
          d  = req_data[r*WIDTH +: WIDTH];
          sh = req_shift[r*SW +: SW];
          exp_q.push_back({TW'(r), d << sh});
          acc_cnt++;
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: tag %0d data %0h with nothing expected", rsp_tag, rsp_data);
        end else begin
          e = exp_q.pop_front();
          check_w("rsp_data", rsp_data, e[WIDTH-1:0]);
          check_n("rsp_tag", 32'(rsp_tag), 32'(e[WIDTH +: TW]));
        end
        rsp_cnt++;
      end
    end
  end

  // Stimulus
  initial begin
    int n;
    int n_acc;
    bit seen;
    int base_acc;
    int base_rsp;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] one139;
    logic [WIDTH-1:0] zero_w;

    zero_w = '0;
    one139 = '0;
    one139[139] = 1'b1;

    vecs[0]  = '{4'b1111, {5{28'h1234567}}, 8'd0,   4'b1000};
    vecs[1]  = '{4'b1111, {5{28'hA5A5A5A}}, 8'd1,   4'b0001};
    vecs[2]  = '{4'b1111, {5{28'hFFFFFFF}}, 8'd15,  4'b0010};
    vecs[3]  = '{4'b1111, {5{28'h0F0F0F0}}, 8'd16,  4'b0100};
    vecs[4]  = '{4'b0001, {5{28'h8000001}}, 8'd17,  4'b0001};
    vecs[5]  = '{4'b1010, {5{28'hDEADBEE}}, 8'd31,  4'b0010};
    vecs[6]  = '{4'b1010, {5{28'h7654321}}, 8'd100, 4'b1000};
    vecs[7]  = '{4'b0000, {5{28'h1111111}}, 8'd3,   4'b0000};
    vecs[8]  = '{4'b0110, {5{28'hCAFEF00}}, 8'd139, 4'b0010};
    vecs[9]  = '{4'b0101, {5{28'h0000003}}, 8'd137, 4'b0100};
    vecs[10] = '{4'b1001, {5{28'h5555555}}, 8'd200, 4'b1000};
    vecs[11] = '{4'b0011, {5{28'h3C3C3C3}}, 8'd64,  4'b0001};

    // Reset state, with requests pending
    reset = 1'b1;
    req_valid = '1;
    req_data = '0;
    req_shift = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_n("reset_req_ready", 32'(req_ready), 32'd0);
    check_n("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_w("reset_rsp_data", rsp_data, zero_w);
    check_n("reset_rsp_tag", 32'(rsp_tag), 32'd0);
    check_n("reset_inflight", 32'(inflight), 32'd0);
    step();
    reset = 1'b0;
    req_valid = '0;

    // Round robin from reset: 0,1,2,3,0,...
    for (int r = 0; r < NREQ; r++) set_req(r, WIDTH'(r + 1), SW'(r));
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_n("rr_grant", 32'(req_ready), 32'(1) << (i % 4));
      step();
    end
    req_valid = '0;
    drain();

    // Single request: requester 2, data 1, shift 139
    set_req(2, WIDTH'(1), 8'd139);
    req_valid = 4'b0100;
    @(negedge clk);
    check_n("single_grant", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    check_n("single_latency", 32'(n), 32'd10);
    check_w("single_data", rsp_data, one139);
    check_n("single_tag", 32'(rsp_tag), 32'd2);
    drain();

    // Directed grant table
    foreach (vecs[k]) begin
      for (int r = 0; r < NREQ; r++) set_req(r, vecs[k].data ^ WIDTH'(r), vecs[k].shift + SW'(r));
      req_valid = vecs[k].valid;
      @(negedge clk);
      check_n("table_grant", 32'(req_ready), 32'(vecs[k].exp_ready));
      step();
    end
    req_valid = '0;
    drain();

    // Backpressure: fill to FIFO_DEPTH, hold output, then release
    rsp_ready = 1'b0;
    set_req(0, {5{28'h0ABCDEF}}, 8'd0);
    req_valid = 4'b0001;
    n_acc = 0;
    hold = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_ready[0]) n_acc++;
      if (i == 25) hold = rsp_data;
      if (i == 28) check_w("stall_hold", rsp_data, hold);
      step();
      set_req(0, {5{28'h0ABCDEF}} ^ WIDTH'(i * 977), SW'(i % 20));
    end
    check_n("bp_accepts", 32'(n_acc), 32'd16);
    @(negedge clk);
    check_n("bp_ready_low", 32'(req_ready), 32'd0);
    check_n("bp_inflight", 32'(inflight), 32'd16);
    step();
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (req_ready[0]) seen = 1'b1;
      step();
    end
    check_n("bp_resume", 32'(seen), 32'd1);
    req_valid = '0;
    drain();

    // Out-of-range shift: all ones shifted by 200
    set_req(1, '1, 8'd200);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    check_w("oor_data", rsp_data, zero_w);
    check_n("oor_tag", 32'(rsp_tag), 32'd1);
    drain();

    // Reset with five operations in flight
    req_valid = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      set_req(3, WIDTH'(i + 7), SW'(i));
      step();
    end
    req_valid = '0;
    @(negedge clk);
    check_n("pre_reset_inflight", 32'(inflight), 32'd5);
    @(posedge clk);
    #2;
    reset = 1'b1;
    req_valid = 4'b1111;
    #1;
    check_n("mid_reset_req_ready", 32'(req_ready), 32'd0);
    check_n("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_n("mid_reset_inflight", 32'(inflight), 32'd0);
    check_w("mid_reset_rsp_data", rsp_data, zero_w);
    check_n("mid_reset_rsp_tag", 32'(rsp_tag), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = '0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rsp_valid) seen = 1'b1;
    end
    check_n("post_reset_no_rsp", 32'(seen), 32'd0);

    // Throughput: 100 back-to-back acceptances
    base_acc = acc_cnt;
    base_rsp = rsp_cnt;
    req_valid = 4'b1111;
    for (int i = 0; i < 100; i++) begin
      for (int r = 0; r < NREQ; r++)
        set_req(r, WIDTH'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()}),
                SW'($urandom_range(0, 150)));
      step();
    end
    req_valid = '0;
    repeat (10) step();
    @(negedge clk);
    #1;
    check_n("tput_accepts", 32'(acc_cnt - base_acc), 32'd100);
    check_n("tput_responses", 32'(rsp_cnt - base_rsp), 32'd100);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 140: operand width in bits.
REQ-002 SHALL have parameter STAGES, default 10: latency of the internal pipelined shifter.
REQ-003 SHALL have parameter STAGE_POW, default 4: per-stage shift bound, 2^STAGE_POW.
REQ-004 SHALL have parameter NREQ, default 4: number of requesters, at least 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16: response buffer entries; elaboration error if below STAGES+2.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port req_valid, input, NREQ bits: per-requester request strobe.
REQ-009 SHALL have port req_ready, output, NREQ bits: per-requester grant; a request is accepted when valid and ready are both high at a clk edge.
REQ-010 SHALL have port req_data, input, NREQ*WIDTH bits: operands, requester r at slice r.
REQ-011 SHALL have port req_shift, input, NREQ*$clog2(WIDTH) bits: shift amounts, requester r at slice r.
REQ-012 SHALL have port rsp_valid, output, 1 bit: response available.
REQ-013 SHALL have port rsp_ready, input, 1 bit: consumer accepts the response.
REQ-014 SHALL have port rsp_data, output, WIDTH bits: shifted result.
REQ-015 SHALL have port rsp_tag, output, $clog2(NREQ) bits: index of the originating requester.
REQ-016 SHALL have port inflight, output, $clog2(FIFO_DEPTH+1) bits: operations in the shifter plus FIFO occupancy.

Function
REQ-017 SHALL raise at most one req_ready bit per cycle, and only to a requester with req_valid high, a combinational function of req_valid, the round-robin pointer and the credit check.
REQ-018 SHALL use round-robin arbitration: search starts at index last_grant+1 modulo NREQ; last_grant updates only on an acceptance.
REQ-019 SHALL assert no req_ready unless inflight < FIFO_DEPTH (credit check); a same-cycle FIFO pop is not credited.
REQ-020 SHALL drive the shifter with the granted requester's data and shift in the accepting cycle, and with zero data otherwise.
REQ-021 SHALL replace the operand with zero when the accepted shift is WIDTH or more, so rsp_data is all zeros.
REQ-022 SHALL carry a valid bit and tag through a STAGES-deep register chain aligned with the shifter.
REQ-023 SHALL write the shifter output and tag into the FIFO at edge k+STAGES for an acceptance at edge k, with rsp_valid high from that edge when the FIFO was empty (no fall-through).
REQ-024 SHALL deliver responses in acceptance order, with one pop per rsp_valid & rsp_ready edge.
REQ-025 SHALL hold rsp_data and rsp_tag stable while rsp_valid is high and rsp_ready is low.
REQ-026 SHALL handle a simultaneous FIFO write and pop in the same edge, with occupancy unchanged.
REQ-027 SHALL sustain one acceptance per cycle indefinitely while rsp_ready stays high.
REQ-028 SHALL give inflight = pipeline valid count + FIFO count, never exceeding FIFO_DEPTH.

Reset
REQ-029 SHALL, on reset assertion and regardless of clk, clear the valid/tag chain, FIFO pointers and count, and set last_grant to NREQ-1.
REQ-030 SHALL hold req_ready=0, rsp_valid=0, rsp_data=0, rsp_tag=0 and inflight=0 while reset is high.
REQ-031 SHALL discard operations in flight at reset, with no responses produced after release.
REQ-032 SHALL tie the shifter's synchronous reset to reset; its stale data is masked by the cleared valid chain.

Structure
REQ-033 SHALL place the tag width, the inflight width function and the FIFO_DEPTH legality check in the shared shift package.
REQ-034 SHALL instantiate the existing leftShiftPipelined shifter, passing WIDTH, STAGES and STAGE_POW.
REQ-035 SHALL implement the response buffer as one new sub-module, shift_rsp_fifo: a synchronous FIFO of {tag, data} with count output.

Verification
REQ-036 SHALL cover single request: req 2, data=1, shift=139, rsp_ready=1 -> rsp_valid rises 10 edges after acceptance; data bit 139 only; tag=2.
REQ-037 SHALL cover round robin: all four valid continuously -> grant order 0,1,2,3,0,…; tags returned in the same order.
REQ-038 SHALL cover backpressure: rsp_ready=0, req 0 always valid -> exactly 16 acceptances, then req_ready=0 and inflight=16; raising rsp_ready yields 16 in-order responses, and acceptance resumes.
REQ-039 SHALL cover out-of-range shift: data all ones, shift=200 -> rsp_data=0.
REQ-040 SHALL cover mid-operation reset: assert reset with 5 in flight -> outputs zero immediately, and no rsp_valid after release until new acceptances.
REQ-041 SHALL cover throughput: 100 back-to-back requests with rsp_ready=1 -> 100 responses in 110 cycles, and each result matches the reference model data<<shift.
